// File: rtl/ifetch_prefetch.sv
// Instruction fetch stage: credit-limited in-order word fetch into a small prefetch FIFO,
// with branch redirect that drains wrong-path responses before refetching.
module ifetch_prefetch #(
   parameter int              PCW      = 64,
   parameter int              ADDRW    = 8,
   parameter int              INSTRW   = 32,
   parameter int              DEPTH    = 4,
   parameter logic [PCW-1:0]  RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDRW-1:0]  imem_req_addr,
   input  logic              imem_rsp_valid,
   input  logic [INSTRW-1:0] imem_rsp_data,
   input  logic              redirect_valid,
   input  logic [PCW-1:0]    redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [INSTRW-1:0] out_instr,
   output logic [PCW-1:0]    out_pc
);
   // state | meaning
   // IDLE  | first cycle after reset, no requests, redirect ignored
   // RUN   | normal fetch, responses pushed into the FIFO
   // FLUSH | wrong-path responses dropped until nothing is outstanding

   localparam int CW  = $clog2(DEPTH + 1);
   localparam int CW1 = CW + 1;
   localparam int AW  = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t            state;
   logic [PCW-1:0]    fetch_pc;
   logic [CW-1:0]     outstanding;
   logic [CW-1:0]     fifo_count;
   logic [PCW-1:0]    tag_q [DEPTH];
   logic [AW-1:0]     tag_wr;
   logic [AW-1:0]     tag_rd;
   logic [INSTRW-1:0] fifo_instr [DEPTH];
   logic [PCW-1:0]    fifo_pc [DEPTH];
   logic [AW-1:0]     fifo_wr;
   logic [AW-1:0]     fifo_rd;

   logic [CW:0]       credit_used;
   logic              accept;
   logic              redirect;
   logic              rsp_take;
   logic              push;
   logic              pop;
   logic [CW-1:0]     outstanding_after_rsp;

   // Every word either in flight or buffered holds one credit, so the FIFO can never overflow.
   assign credit_used    = {1'b0, outstanding} + {1'b0, fifo_count};
   assign imem_req_valid = (state == RUN) && (credit_used < CW1'(DEPTH)) && !redirect_valid;
   assign imem_req_addr  = fetch_pc[ADDRW-1:0];
   assign accept         = imem_req_valid && imem_req_ready;
   assign redirect       = redirect_valid && (state != IDLE);
   // Responses with nothing outstanding are leftovers from before a reset.
   assign rsp_take       = imem_rsp_valid && (outstanding != '0) && (state != IDLE);
   assign push           = rsp_take && (state == RUN) && !redirect;
   assign out_valid      = (fifo_count != '0);
   assign pop            = out_valid && out_ready;
   assign out_instr      = fifo_instr[fifo_rd];
   assign out_pc         = fifo_pc[fifo_rd];
   assign outstanding_after_rsp = outstanding - CW'(rsp_take);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         fifo_count  <= '0;
         tag_wr      <= '0;
         tag_rd      <= '0;
         fifo_wr     <= '0;
         fifo_rd     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            tag_q[i]      <= '0;
            fifo_instr[i] <= '0;
            fifo_pc[i]    <= '0;
         end
      end else begin
         outstanding <= outstanding_after_rsp + CW'(accept);

         // Tag queue tracks every request in flight, wrong-path ones included.
         if (accept) begin
            tag_q[tag_wr] <= fetch_pc;
            tag_wr        <= tag_wr + AW'(1);
         end
         if (rsp_take)
            tag_rd <= tag_rd + AW'(1);

         if (redirect)
            fetch_pc <= redirect_pc;
         else if (accept)
            fetch_pc <= fetch_pc + PCW'(1);

         if (redirect) begin
            fifo_count <= '0;
            fifo_wr    <= '0;
            fifo_rd    <= '0;
         end else begin
            if (push) begin
               fifo_instr[fifo_wr] <= imem_rsp_data;
               fifo_pc[fifo_wr]    <= tag_q[tag_rd];
               fifo_wr             <= fifo_wr + AW'(1);
            end
            if (pop)
               fifo_rd <= fifo_rd + AW'(1);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
         end

         case (state)
            IDLE:    state <= RUN;
            RUN:     if (redirect && (outstanding_after_rsp != '0)) state <= FLUSH;
            FLUSH: begin
               if (outstanding_after_rsp == '0) state <= RUN;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
